instr_encoder: RTL and testbench

//  Inverse of the control decoder. Packs operation-class and field inputs into 32-bit MIPS instruction words.

---
 rtl/mips_isa_pkg.sv | 37 +++
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_field_pack.sv | 34 +++
 rtl/instr_encoder.sv | 133 +++++++++++++
 tb/tb_instr_encoder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcodes (also used by the control decoder),
// encoder operation-select codes and the encoder FSM state encoding.
package mips_isa_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  typedef enum logic [3:0] {
    OP_ARI  = 4'd0,
    OP_ADDI = 4'd1,
    OP_ANDI = 4'd2,
    OP_LW   = 4'd3,
    OP_SW   = 4'd4,
    OP_BEQ  = 4'd5,
    OP_BNE  = 4'd6,
    OP_J    = 4'd7
  } op_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] pack_itype(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of the instruction encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_last, op_sel, rs, rt, rd, shamt, funct, imm, target, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_last, op_sel, rs, rt, rd, shamt, funct, imm, target, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_field_pack.sv
// Combinational packer: operation select plus register/immediate fields into a
// 32-bit MIPS word, flagging op_sel codes outside the supported set.
module instr_field_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] instr,
  output logic        illegal
);

  always_comb begin
    instr   = '0;
    illegal = 1'b0;
    case (op_sel)
      OP_ARI:  instr = {OPC_RTYPE, rs, rt, rd, shamt, funct};
      OP_ADDI: instr = pack_itype(OPC_ADDI, rs, rt, imm);
      OP_ANDI: instr = pack_itype(OPC_ANDI, rs, rt, imm);
      OP_LW:   instr = pack_itype(OPC_LW, rs, rt, imm);
      OP_SW:   instr = pack_itype(OPC_SW, rs, rt, imm);
      OP_BEQ:  instr = pack_itype(OPC_BEQ, rs, rt, imm);
      OP_BNE:  instr = pack_itype(OPC_BNE, rs, rt, imm);
      OP_J:    instr = {OPC_J, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program-loader encoder: accepts field bundles, emits encoded words with byte
// addresses through a one-deep output register toward instruction memory.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_encoder_if.slave    bus,
  output logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal
);

  state_e            state_reg, state_next;
  logic              out_valid_reg, out_valid_next;
  logic [31:0]       out_instr_reg, out_instr_next;
  logic [ADDR_W-1:0] out_addr_reg, out_addr_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic              err_reg, err_next;

  logic [31:0] packed_instr;
  logic        packed_illegal;
  logic        in_ready_c;
  logic        accept;
  logic        xfer;

  instr_field_pack u_pack (
    .op_sel  (bus.op_sel),
    .rs      (bus.rs),
    .rt      (bus.rt),
    .rd      (bus.rd),
    .shamt   (bus.shamt),
    .funct   (bus.funct),
    .imm     (bus.imm),
    .target  (bus.target),
    .instr   (packed_instr),
    .illegal (packed_illegal)
  );

  // Output register can take a new word whenever it is empty or draining this cycle.
  assign in_ready_c = (state_reg == ST_RUN) && (!out_valid_reg || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign xfer       = out_valid_reg && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    out_valid_next = out_valid_reg;
    out_instr_next = out_instr_reg;
    out_addr_next  = out_addr_reg;
    count_next     = count_reg;
    err_next       = err_reg;

    // A transfer retires the current word; the following word lands at the next address.
    if (xfer) begin
      out_valid_next = 1'b0;
      out_addr_next  = out_addr_reg + ADDR_W'(4);
      count_next     = count_reg + ADDR_W'(1);
    end

    if (accept) begin
      if (packed_illegal) begin
        err_next = 1'b1;
      end else begin
        out_valid_next = 1'b1;
        out_instr_next = packed_instr;
      end
    end

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_RUN;
          out_addr_next = BASE_ADDR;
          count_next    = '0;
          err_next      = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept && bus.in_last) begin
          state_next = out_valid_next ? ST_FLUSH : ST_DONE;
        end
      end
      ST_FLUSH: begin
        if (xfer) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_instr_reg <= '0;
      out_addr_reg  <= BASE_ADDR;
      count_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_instr_reg <= out_instr_next;
      out_addr_reg  <= out_addr_next;
      count_reg     <= count_next;
      err_reg       <= err_next;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_instr = out_instr_reg;
  assign bus.out_addr  = out_addr_reg;
  assign word_count    = count_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign done          = (state_reg == ST_DONE);
  assign err_illegal   = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: a 32-bit-address instance for
// the main scenarios and a 4-bit-address instance for address wrap.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        start_a;
  logic        start_b;
  logic [31:0] wc_a;
  logic [3:0]  wc_b;
  logic        busy_a, done_a, err_a;
  logic        busy_b, done_b, err_b;

  int checks = 0;
  int errors = 0;

  instr_encoder_if #(.ADDR_W(32)) ifa ();
  instr_encoder_if #(.ADDR_W(4))  ifb ();

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_a),
    .bus         (ifa.slave),
    .word_count  (wc_a),
    .busy        (busy_a),
    .done        (done_a),
    .err_illegal (err_a)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_b),
    .bus         (ifb.slave),
    .word_count  (wc_b),
    .busy        (busy_b),
    .done        (done_b),
    .err_illegal (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifa.out_valid && ifa.out_ready)
      $display("xfer A addr=%08h instr=%08h", ifa.out_addr, ifa.out_instr);
    if (ifb.out_valid && ifb.out_ready)
      $display("xfer B addr=%01h instr=%08h", ifb.out_addr, ifb.out_instr);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [3:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                         input logic last);
    ifa.in_valid = v;
    ifa.op_sel   = op;
    ifa.rs       = rs;
    ifa.rt       = rt;
    ifa.rd       = rd;
    ifa.shamt    = sh;
    ifa.funct    = fn;
    ifa.imm      = im;
    ifa.target   = tg;
    ifa.in_last  = last;
  endtask

  task automatic test_reset();
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ifa.out_valid); end
    checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", ifa.in_ready); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b done=%b err=%b expected 0 0 0", busy_a, done_a, err_a); end
    checks++; if (ifa.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h expected 00000000", ifa.out_instr); end
    checks++; if (ifa.out_addr !== 32'h0 || wc_a !== 32'h0) begin errors++; $display("FAIL reset_addr_count: got addr=%h count=%0d expected 0 0", ifa.out_addr, wc_a); end
    checks++; if (ifb.out_addr !== 4'hC) begin errors++; $display("FAIL reset_base_addr_b: got %h expected c", ifb.out_addr); end
    // A bundle offered while idle must be ignored.
    drive_a(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
    tick();
    checks++; if (ifa.out_valid !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL idle_no_accept: got out_valid=%b busy=%b expected 0 0", ifa.out_valid, busy_a); end
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
  endtask

  task automatic test_single();
    ifa.out_ready = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++; if (busy_a !== 1'b1 || ifa.in_ready !== 1'b1) begin errors++; $display("FAIL single_run: got busy=%b in_ready=%b expected 1 1", busy_a, ifa.in_ready); end
    drive_a(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1);
    tick();
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    checks++; if (ifa.out_valid !== 1'b1 || ifa.out_instr !== 32'h00221820 || ifa.out_addr !== 32'h0) begin errors++; $display("FAIL single_word: got v=%b instr=%h addr=%h expected 1 00221820 00000000", ifa.out_valid, ifa.out_instr, ifa.out_addr); end
    checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL single_flush_ready: got %b expected 0", ifa.in_ready); end
    tick();
    checks++; if (done_a !== 1'b1 || wc_a !== 32'd1 || ifa.out_valid !== 1'b0) begin errors++; $display("FAIL single_done: got done=%b count=%0d v=%b expected 1 1 0", done_a, wc_a, ifa.out_valid); end
    tick();
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL single_idle: got done=%b busy=%b expected 0 0", done_a, busy_a); end
  endtask

  task automatic test_back_to_back();
    ifa.out_ready = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drive_a(1'b1, 4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'd5, 26'h0, 1'b0);
    tick();
    checks++; if (ifa.out_instr !== 32'h20080005 || ifa.out_addr !== 32'h0) begin errors++; $display("FAIL b2b_addi: got instr=%h addr=%h expected 20080005 00000000", ifa.out_instr, ifa.out_addr); end
    drive_a(1'b1, 4'd3, 5'd29, 5'd9, 5'd0, 5'd0, 6'h0, 16'd4, 26'h0, 1'b0);
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", ifa.in_ready); end
    tick();
    checks++; if (ifa.out_instr !== 32'h8FA90004 || ifa.out_addr !== 32'h4) begin errors++; $display("FAIL b2b_lw: got instr=%h addr=%h expected 8fa90004 00000004", ifa.out_instr, ifa.out_addr); end
    drive_a(1'b1, 4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1);
    start_a = 1'b1;  // must be ignored outside IDLE
    tick();
    start_a = 1'b0;
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    checks++; if (ifa.out_instr !== 32'h08000010 || ifa.out_addr !== 32'h8 || wc_a !== 32'd2) begin errors++; $display("FAIL b2b_j: got instr=%h addr=%h count=%0d expected 08000010 00000008 2", ifa.out_instr, ifa.out_addr, wc_a); end
    tick();
    checks++; if (done_a !== 1'b1 || wc_a !== 32'd3) begin errors++; $display("FAIL b2b_done: got done=%b count=%0d expected 1 3", done_a, wc_a); end
    tick();
  endtask

  task automatic test_stall();
    ifa.out_ready = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drive_a(1'b1, 4'd4, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'hFFFC, 26'h0, 1'b0);
    tick();
    drive_a(1'b1, 4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'd3, 26'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++; if (ifa.out_valid !== 1'b1 || ifa.out_instr !== 32'hAC43FFFC || ifa.out_addr !== 32'h0) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b instr=%h addr=%h expected 1 ac43fffc 00000000", i, ifa.out_valid, ifa.out_instr, ifa.out_addr); end
      checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, ifa.in_ready); end
      tick();
    end
    ifa.out_ready = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", ifa.in_ready); end
    tick();
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    checks++; if (ifa.out_instr !== 32'h10220003 || ifa.out_addr !== 32'h4 || wc_a !== 32'd1) begin errors++; $display("FAIL stall_beq: got instr=%h addr=%h count=%0d expected 10220003 00000004 1", ifa.out_instr, ifa.out_addr, wc_a); end
    tick();
    checks++; if (done_a !== 1'b1 || wc_a !== 32'd2) begin errors++; $display("FAIL stall_done: got done=%b count=%0d expected 1 2", done_a, wc_a); end
    tick();
  endtask

  task automatic test_illegal();
    ifa.out_ready = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drive_a(1'b1, 4'd2, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'h0, 1'b0);
    tick();
    checks++; if (ifa.out_instr !== 32'h308500FF || ifa.out_addr !== 32'h0) begin errors++; $display("FAIL illegal_andi: got instr=%h addr=%h expected 308500ff 00000000", ifa.out_instr, ifa.out_addr); end
    drive_a(1'b1, 4'd9, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1, 1'b0);
    tick();
    checks++; if (ifa.out_valid !== 1'b0 || err_a !== 1'b1 || wc_a !== 32'd1) begin errors++; $display("FAIL illegal_consumed: got v=%b err=%b count=%0d expected 0 1 1", ifa.out_valid, err_a, wc_a); end
    drive_a(1'b1, 4'd6, 5'd6, 5'd7, 5'd0, 5'd0, 6'h0, 16'h8000, 26'h0, 1'b1);
    tick();
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    checks++; if (ifa.out_instr !== 32'h14C78000 || ifa.out_addr !== 32'h4 || err_a !== 1'b1) begin errors++; $display("FAIL illegal_next_addr: got instr=%h addr=%h err=%b expected 14c78000 00000004 1", ifa.out_instr, ifa.out_addr, err_a); end
    tick();
    checks++; if (done_a !== 1'b1 || wc_a !== 32'd2) begin errors++; $display("FAIL illegal_done: got done=%b count=%0d expected 1 2", done_a, wc_a); end
    tick();
    checks++; if (err_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL illegal_sticky: got err=%b busy=%b expected 1 0", err_a, busy_a); end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++; if (err_a !== 1'b0 || wc_a !== 32'd0 || ifa.out_addr !== 32'h0) begin errors++; $display("FAIL illegal_clear: got err=%b count=%0d addr=%h expected 0 0 00000000", err_a, wc_a, ifa.out_addr); end
  endtask

  // Entered with dut_a already in RUN after the previous start.
  task automatic test_reset_mid();
    ifa.out_ready = 1'b1;
    drive_a(1'b1, 4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'd5, 26'h0, 1'b0);
    tick();
    drive_a(1'b1, 4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1);
    tick();
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    ifa.out_ready = 1'b0;
    checks++; if (ifa.out_valid !== 1'b1 || ifa.out_addr !== 32'h4 || busy_a !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got v=%b addr=%h busy=%b expected 1 00000004 1", ifa.out_valid, ifa.out_addr, busy_a); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ifa.out_valid !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_async: got v=%b busy=%b expected 0 0", ifa.out_valid, busy_a); end
    checks++; if (ifa.out_addr !== 32'h0 || wc_a !== 32'd0 || ifa.out_instr !== 32'h0) begin errors++; $display("FAIL rstmid_values: got addr=%h count=%0d instr=%h expected 0 0 0", ifa.out_addr, wc_a, ifa.out_instr); end
    tick();
    rst_n = 1'b1;
    ifa.out_ready = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drive_a(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1);
    tick();
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    checks++; if (ifa.out_instr !== 32'h00221820 || ifa.out_addr !== 32'h0) begin errors++; $display("FAIL rstmid_restart: got instr=%h addr=%h expected 00221820 00000000", ifa.out_instr, ifa.out_addr); end
    tick();
    checks++; if (done_a !== 1'b1 || wc_a !== 32'd1) begin errors++; $display("FAIL rstmid_done: got done=%b count=%0d expected 1 1", done_a, wc_a); end
    tick();
  endtask

  task automatic test_wrap();
    ifb.out_ready = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    ifb.in_valid = 1'b1; ifb.op_sel = 4'd1; ifb.rs = 5'd0; ifb.rt = 5'd8; ifb.imm = 16'd5; ifb.in_last = 1'b0;
    tick();
    checks++; if (ifb.out_instr !== 32'h20080005 || ifb.out_addr !== 4'hC) begin errors++; $display("FAIL wrap_first: got instr=%h addr=%h expected 20080005 c", ifb.out_instr, ifb.out_addr); end
    ifb.op_sel = 4'd7; ifb.target = 26'h10; ifb.in_last = 1'b1;
    tick();
    ifb.in_valid = 1'b0; ifb.in_last = 1'b0;
    checks++; if (ifb.out_instr !== 32'h08000010 || ifb.out_addr !== 4'h0 || wc_b !== 4'd1) begin errors++; $display("FAIL wrap_second: got instr=%h addr=%h count=%0d expected 08000010 0 1", ifb.out_instr, ifb.out_addr, wc_b); end
    tick();
    checks++; if (done_b !== 1'b1 || wc_b !== 4'd2) begin errors++; $display("FAIL wrap_done: got done=%b count=%0d expected 1 2", done_b, wc_b); end
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_last = 1'b0; ifb.op_sel = 4'd0;
    ifb.rs = 5'd0; ifb.rt = 5'd0; ifb.rd = 5'd0; ifb.shamt = 5'd0;
    ifb.funct = 6'h0; ifb.imm = 16'h0; ifb.target = 26'h0; ifb.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_wrap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
